// File: rtl/icx_readout.sv
// icx_readout: receive side of the ICX CCD timing generator.
// Aligns timing (hblank/cob/frame_start) to the ADC pipeline, measures the
// per-line optical-black level, crops the effective window, tags sof/eol and
// buffers pixels in a FWFT FIFO towards a valid/ready consumer.
// Optional: ICX_READOUT_BLACK_SUB_EN subtracts black_level (saturating at 0)
// from each pushed pixel.
module icx_readout #(
  parameter int DATA_W      = 14,
  parameter int ADC_LATENCY = 3,
  parameter int SKIP_PIXELS = 0,
  parameter int LINE_PIXELS = 1392,
  parameter int SKIP_LINES  = 8,
  parameter int FRAME_LINES = 1032,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              hblank,
  input  logic              cob,
  input  logic              adc_strobe,
  input  logic [DATA_W-1:0] adc_data,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [DATA_W-1:0] black_level,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned LAT   = ADC_LATENCY;
  localparam int          PMAX  = (LINE_PIXELS > SKIP_PIXELS) ? LINE_PIXELS : SKIP_PIXELS;
  localparam int          PC_W  = $clog2(PMAX + 1);
  localparam int          LC_W  = $clog2(SKIP_LINES + FRAME_LINES + 1);
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          ACC_W = DATA_W + 4;

  typedef enum logic [1:0] {IDLE, WAIT_LINE, SKIP, ACTIVE} state_t;

  state_t            state, state_n, st;
  logic [LAT-1:0][2:0] tsr;
  logic              hb_d, cob_d, fs_d, hb_q, cob_q;
  logic              hb_fall, hb_rise, cob_fall, cob_rise;
  logic [PC_W-1:0]   pix_cnt, pix_n;
  logic [LC_W-1:0]   line_cnt, line_n;
  logic              sof_pend, sof_n;
  logic              push_req, push_sof, push_eol, push, pop, full, drop;
  logic [ACC_W-1:0]  acc;
  logic [4:0]        bcnt;
  logic [DATA_W-1:0] pix_val;
  logic [17:0]       mem [FIFO_DEPTH];
  logic [17:0]       head;
  logic [AW:0]       wr_ptr, rd_ptr;

  assign {fs_d, cob_d, hb_d} = tsr[LAT-1];
  assign hb_fall  = hb_q & ~hb_d;
  assign hb_rise  = ~hb_q & hb_d;
  assign cob_fall = cob_q & ~cob_d;
  assign cob_rise = ~cob_q & cob_d;
  assign busy     = (state != IDLE);

  // Delay timing inputs to line up with the ADC samples; keep previous values for edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsr   <= '0;
      hb_q  <= 1'b0;
      cob_q <= 1'b0;
    end else begin
      tsr[0] <= {frame_start, cob, hblank};
      for (int unsigned i = 1; i < LAT; i++) tsr[i] <= tsr[i-1];
      hb_q  <= hb_d;
      cob_q <= cob_d;
    end
  end

  // Next state / counters; the falling-edge sample is already the first pixel,
  // so the entry state is resolved into st before the sample is handled
  always_comb begin
    state_n  = state;
    st       = state;
    pix_n    = pix_cnt;
    line_n   = line_cnt;
    sof_n    = sof_pend;
    push_req = 1'b0;
    push_sof = 1'b0;
    push_eol = 1'b0;
    if (fs_d) begin
      state_n = WAIT_LINE;
      line_n  = '0;
      pix_n   = '0;
      sof_n   = 1'b1;
    end else begin
      if (state == WAIT_LINE && hb_fall) begin
        st      = (SKIP_PIXELS == 0) ? ACTIVE : SKIP;
        state_n = st;
        pix_n   = '0;
      end
      case (st)
        SKIP: if (adc_strobe) begin
          if (pix_n == PC_W'(SKIP_PIXELS - 1)) begin
            state_n = ACTIVE;
            pix_n   = '0;
          end else begin
            pix_n = pix_n + 1'b1;
          end
        end
        ACTIVE: begin
          if (hb_rise) begin
            line_n  = line_cnt + 1'b1;
            pix_n   = '0;
            state_n = WAIT_LINE;
          end else if (adc_strobe) begin
            push_req = (line_cnt >= LC_W'(SKIP_LINES));
            push_sof = sof_pend;
            if (push_req) sof_n = 1'b0;
            if (pix_n == PC_W'(LINE_PIXELS - 1)) begin
              push_eol = 1'b1;
              pix_n    = '0;
              line_n   = line_cnt + 1'b1;
              state_n  = (line_n == LC_W'(SKIP_LINES + FRAME_LINES)) ? IDLE : WAIT_LINE;
            end else begin
              pix_n = pix_n + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      line_cnt <= '0;
      sof_pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      pix_cnt  <= pix_n;
      line_cnt <= line_n;
      sof_pend <= sof_n;
      if (fs_d) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // Optical-black accumulation over the first 16 samples of each cob window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      bcnt        <= '0;
      black_level <= '0;
    end else begin
      if (cob_rise) begin
        acc  <= adc_strobe ? ACC_W'(adc_data) : '0;
        bcnt <= adc_strobe ? 5'd1 : 5'd0;
      end else if (cob_d && adc_strobe && bcnt != 5'd16) begin
        acc  <= acc + ACC_W'(adc_data);
        bcnt <= bcnt + 5'd1;
      end
      if (cob_fall && bcnt == 5'd16) black_level <= acc[ACC_W-1:4];
    end
  end

  // Pixel value presented to the FIFO
  always_comb begin
`ifdef ICX_READOUT_BLACK_SUB_EN
    pix_val = (adc_data > black_level) ? (adc_data - black_level) : '0;
`else
    pix_val = adc_data;
`endif
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pix_valid = (wr_ptr != rd_ptr);
  assign pop       = pix_valid & pix_ready;
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign pix_data  = head[15:0];
  assign pix_sof   = pix_valid & head[17];
  assign pix_eol   = pix_valid & head[16];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_sof, push_eol, 16'(pix_val)};
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_icx_readout.sv
// Scoreboard bench for icx_readout (SKIP_LINES=1, FRAME_LINES=5, LINE_PIXELS=4).
// Stimulus is described in ADC-aligned time: step() drives timing inputs now
// and the matching sample ADC_LATENCY (3) cycles later.
module tb_icx_readout;
  localparam int LP = 4;

  logic        clk = 1'b0;
  logic        reset, frame_start, hblank, cob, adc_strobe, pix_ready;
  logic [13:0] adc_data;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, overflow, busy;
  logic [13:0] black_level;

  int          total = 0;
  int          bad = 0;
  int          popped = 0;
  int          base_pop;
  int          exp_black = 0;
  logic [17:0] sbq[$];
  logic [17:0] mon_exp;
  logic        dl_s[3];
  logic [13:0] dl_d[3];

  icx_readout #(.DATA_W(14), .ADC_LATENCY(3), .SKIP_PIXELS(0), .LINE_PIXELS(LP),
                .SKIP_LINES(1), .FRAME_LINES(5), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .hblank(hblank), .cob(cob),
    .adc_strobe(adc_strobe), .adc_data(adc_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .black_level(black_level), .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ent(input bit sof, input bit eol, input int d);
    int v;
    v = d;
`ifdef ICX_READOUT_BLACK_SUB_EN
    v = (d > exp_black) ? d - exp_black : 0;
`endif
    return {sof, eol, 16'(v)};
  endfunction

  task automatic step(input bit hb, input bit cb, input bit fs, input bit s, input int d);
    hblank      = hb;
    cob         = cb;
    frame_start = fs;
    adc_strobe  = dl_s[2];
    adc_data    = dl_d[2];
    dl_s[2] = dl_s[1]; dl_d[2] = dl_d[1];
    dl_s[1] = dl_s[0]; dl_d[1] = dl_d[0];
    dl_s[0] = s;       dl_d[0] = 14'(d);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    repeat (6) step(1, 0, 0, 0, 0);
  endtask

  task automatic frame_pulse();
    step(1, 0, 1, 0, 0);
  endtask

  task automatic send_line(input int npix, input int base, input int stp, input int npush, input bit sof);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < npix; i++) begin
      if (i < npush) sbq.push_back(ent(sof && i == 0, i == LP - 1, base + i * stp));
      step(0, 0, 0, 1, base + i * stp);
    end
    step(1, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name, input int n_exp);
    int i;
    i = 0;
    while (sbq.size() > 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({name, "_queue_left"}, sbq.size(), 0);
    chk({name, "_count"}, popped - base_pop, n_exp);
  endtask

  // Monitor: compare every accepted output beat against the scoreboard head
  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      total++;
      popped++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL pix_unexpected: got %h expected none", {pix_sof, pix_eol, pix_data});
      end else begin
        mon_exp = sbq.pop_front();
        if ({pix_sof, pix_eol, pix_data} !== mon_exp) begin
          bad++;
          $display("FAIL pix_out: got sof=%0b eol=%0b data=%0d expected sof=%0b eol=%0b data=%0d",
                   pix_sof, pix_eol, pix_data, mon_exp[17], mon_exp[16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; frame_start = 0; hblank = 1; cob = 0; adc_strobe = 0; adc_data = '0;
    pix_ready = 0;
    for (int i = 0; i < 3; i++) begin dl_s[i] = 0; dl_d[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_black", int'(black_level), 0);
    chk("rst_sof", int'(pix_sof), 0);
    chk("rst_eol", int'(pix_eol), 0);
    reset = 1'b0;
    flush();

    // Black level: 27-sample window, only the first 16 count
    for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 100);
    for (int i = 0; i < 11; i++) step(1, 1, 0, 1, 900);
    step(1, 0, 0, 0, 0);
    flush();
    chk("black_27", int'(black_level), 100);
    exp_black = 100;
    // Window with only 10 samples leaves the level unchanged
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 500);
    step(1, 0, 0, 0, 0);
    flush();
    chk("black_short", int'(black_level), 100);

    // Full frame, consumer always ready
    pix_ready = 1;
    base_pop = popped;
    frame_pulse();
    send_line(4, 10, 1, 0, 0);
    send_line(4, 50, 300, 4, 1);
    chk("busy_mid", int'(busy), 1);
    for (int l = 2; l <= 5; l++) send_line(4, 1000 + l * 16, 1, 4, 0);
    flush();
    chk("busy_end", int'(busy), 0);
    drain("frame", 20);

    // Overflow: consumer stalled for a 20-pixel frame
    pix_ready = 0;
    base_pop = popped;
    frame_pulse();
    send_line(4, 10, 1, 0, 0);
    send_line(4, 2000, 3, 4, 1);
    for (int l = 2; l <= 4; l++) send_line(4, 2000 + l * 20, 1, 4, 0);
    send_line(4, 2500, 1, 0, 0);
    flush();
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_busy_end", int'(busy), 0);
    chk("ovf_valid", int'(pix_valid), 1);
    frame_pulse();
    flush();
    chk("ovf_clear", int'(overflow), 0);
    pix_ready = 1;
    drain("ovf", 16);

    // frame_start in the middle of line 1
    pix_ready = 0;
    base_pop = popped;
    frame_pulse();
    send_line(4, 10, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    sbq.push_back(ent(1, 0, 3100));
    sbq.push_back(ent(0, 0, 3101));
    step(0, 0, 0, 1, 3100);
    step(0, 0, 0, 1, 3101);
    step(0, 0, 1, 1, 777);
    step(0, 0, 0, 1, 778);
    step(1, 0, 0, 0, 0);
    send_line(4, 3200, 1, 0, 0);
    send_line(4, 3300, 5, 4, 1);
    flush();
    pix_ready = 1;
    drain("midfs", 6);

    // Reset while ACTIVE with 5 pixels queued
    pix_ready = 0;
    frame_pulse();
    send_line(4, 10, 1, 0, 0);
    send_line(4, 4000, 1, 4, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    sbq.push_back(ent(0, 0, 4100));
    step(0, 0, 0, 1, 4100);
    repeat (4) step(0, 0, 0, 0, 0);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_valid", int'(pix_valid), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", int'(pix_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_black", int'(black_level), 0);
    sbq.delete();
    exp_black = 0;
    reset = 1'b0;
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
